dmem_arbiter_rv32i: RTL

DMEM_ARBITER_RV32I -- requirements
Module: dmem_arbiter_rv32i

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_if.sv | 52 +++++
 rtl/dmem_arb_rr.sv | 35 +++
 rtl/dmem_arbiter_rv32i.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the RV32I data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_C = 2'd1,
        OWN_D = 2'd2
    } arb_state_e;

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SB = 2'b10;

    localparam int LOCK_MAX_DEF = 8;
    localparam int WAIT_MAX_DEF = 15;

endpackage

// File: rtl/dmem_arb_if.sv
// Bus bundle between the core/debug requesters, the arbiter and the data memory.
interface dmem_arb_if;

    logic        c_req;
    logic        c_we;
    logic [1:0]  c_storetype;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;

    logic        d_req;
    logic        d_lock;
    logic        d_we;
    logic [1:0]  d_storetype;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        m_store;
    logic [1:0]  m_storetype;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    logic [1:0]  wdog_err;

    // Requester side; it also plays the memory and supplies m_rdata.
    modport master (
        output c_req, c_we, c_storetype, c_addr, c_wdata,
        output d_req, d_lock, d_we, d_storetype, d_addr, d_wdata,
        output m_rdata,
        input  c_gnt, c_rvalid, c_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_store, m_storetype, m_addr, m_wdata,
        input  wdog_err
    );

    modport slave (
        input  c_req, c_we, c_storetype, c_addr, c_wdata,
        input  d_req, d_lock, d_we, d_storetype, d_addr, d_wdata,
        input  m_rdata,
        output c_gnt, c_rvalid, c_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_store, m_storetype, m_addr, m_wdata,
        output wdog_err
    );

endinterface

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin pick between core and debug; owns the last-grant pointer.
module dmem_arb_rr (
    input  logic clock,
    input  logic reset,
    input  logic req_c_i,
    input  logic req_d_i,
    input  logic gnt_c_i,
    input  logic gnt_d_i,
    output logic pick_d_o
);

    logic last_d_q;
    logic last_d_d;

    always_comb begin
        last_d_d = last_d_q;
        if (gnt_c_i) begin
            last_d_d = 1'b0;
        end else if (gnt_d_i) begin
            last_d_d = 1'b1;
        end
    end

    // Pointer starts at "debug" so the core takes the first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_d_q <= 1'b1;
        end else begin
            last_d_q <= last_d_d;
        end
    end

    assign pick_d_o = req_d_i & (~req_c_i | ~last_d_q);

endmodule

// File: rtl/dmem_arbiter_rv32i.sv
// Core/debug data-memory arbiter with debug bus lock and read-data return.
// Optional starvation watchdog is built when DMEM_ARB_WDOG_EN is defined.
module dmem_arbiter_rv32i
    import dmem_arb_pkg::*;
#(
    parameter int LOCK_MAX = LOCK_MAX_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic       clock,
    input  logic       reset,
    dmem_arb_if.slave  bus
);

    localparam int             LCW      = $clog2(LOCK_MAX + 1);
    localparam logic [LCW-1:0] LOCK_LIM = LCW'(LOCK_MAX);

    arb_state_e     state_q, state_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc;
    logic           c_gnt, d_gnt, pick_d;
    logic           c_rd, d_rd;
    logic           c_rvalid_q, d_rvalid_q;
    logic [31:0]    c_rdata_q, d_rdata_q;

    dmem_arb_rr u_rr (
        .clock    (clock),
        .reset    (reset),
        .req_c_i  (bus.c_req),
        .req_d_i  (bus.d_req),
        .gnt_c_i  (c_gnt),
        .gnt_d_i  (d_gnt),
        .pick_d_o (pick_d)
    );

    // The lock budget is judged on the count including this cycle's grant.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        lock_cnt_inc = lock_cnt_q;
        c_gnt        = 1'b0;
        d_gnt        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.c_req | bus.d_req) begin
                    state_d = pick_d ? OWN_D : OWN_C;
                end
            end
            OWN_C: begin
                c_gnt = bus.c_req;
                if (bus.d_req) begin
                    state_d = OWN_D;
                end else if (bus.c_req) begin
                    state_d = OWN_C;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN_D: begin
                d_gnt        = bus.d_req;
                lock_cnt_inc = lock_cnt_q + LCW'(bus.d_req & bus.d_lock & bus.c_req);
                if (bus.d_lock & bus.d_req & (lock_cnt_inc < LOCK_LIM)) begin
                    state_d = OWN_D;
                end else if (bus.c_req) begin
                    state_d = OWN_C;
                end else if (bus.d_req) begin
                    state_d = OWN_D;
                end else begin
                    state_d = IDLE;
                end
                lock_cnt_d = (state_d == OWN_D) ? lock_cnt_inc : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.m_store     = 1'b0;
        bus.m_storetype = ST_SW;
        bus.m_addr      = '0;
        bus.m_wdata     = '0;
        case (state_q)
            OWN_C: begin
                bus.m_store     = bus.c_we & c_gnt;
                bus.m_storetype = bus.c_storetype;
                bus.m_addr      = bus.c_addr;
                bus.m_wdata     = bus.c_wdata;
            end
            OWN_D: begin
                bus.m_store     = bus.d_we & d_gnt;
                bus.m_storetype = bus.d_storetype;
                bus.m_addr      = bus.d_addr;
                bus.m_wdata     = bus.d_wdata;
            end
            default: ;
        endcase
    end

    assign c_rd = c_gnt & ~bus.c_we;
    assign d_rd = d_gnt & ~bus.d_we;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            c_rvalid_q <= c_rd;
            d_rvalid_q <= d_rd;
            if (c_rd) c_rdata_q <= bus.m_rdata;
            if (d_rd) d_rdata_q <= bus.m_rdata;
        end
    end

    assign bus.c_gnt    = c_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.c_rvalid = c_rvalid_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.c_rdata  = c_rdata_q;
    assign bus.d_rdata  = d_rdata_q;

`ifdef DMEM_ARB_WDOG_EN
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

    logic [3:0] wait_c_q, wait_c_d, wait_d_q, wait_d_d;
    logic [1:0] err_q, err_d;

    // Wait counters saturate; error bits are sticky until reset.
    always_comb begin
        wait_c_d = '0;
        wait_d_d = '0;
        if (bus.c_req & ~c_gnt) begin
            wait_c_d = (wait_c_q == 4'hF) ? wait_c_q : wait_c_q + 4'd1;
        end
        if (bus.d_req & ~d_gnt) begin
            wait_d_d = (wait_d_q == 4'hF) ? wait_d_q : wait_d_q + 4'd1;
        end
        err_d = err_q | {wait_d_d == WAIT_LIM, wait_c_d == WAIT_LIM};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_c_q <= '0;
            wait_d_q <= '0;
            err_q    <= '0;
        end else begin
            wait_c_q <= wait_c_d;
            wait_d_q <= wait_d_d;
            err_q    <= err_d;
        end
    end

    assign bus.wdog_err = err_q;
`else
    logic unused_wait;
    assign unused_wait  = (WAIT_MAX > 0);
    assign bus.wdog_err = 2'b00;
`endif

endmodule
